exception_monitor: RTL and testbench
====================================

EXCEPTION_MONITOR -- requirements
Module: exception_monitor

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, cycles core_rst is held asserted on each (re)start; range 1..15.
REQ-002 Parameter AUTO_RESTART, default 0; 1 = restart the core automatically once a report is accepted.
REQ-003 Reset: one clock, clk; reset port rst is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock, shared with the core.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 exc_in  input  10  core final exception vector (exception_out); nonzero = retiring instruction trapped.
REQ-007 exc_pc  input  32  retire PC, cycle-aligned with exc_in.
REQ-008 restart_req  input  1  host request to restart a halted core; single-cycle pulse or level.
REQ-009 rep_ready  input  1  host accepts the report.
REQ-010 core_rst  output  1  active-high synchronous reset driven into the core.
REQ-011 rep_valid  output  1  exception report pending.
REQ-012 rep_code  output  10  captured exception vector.
REQ-013 rep_cause  output  4  index of the lowest set bit of rep_code.
REQ-014 rep_pc  output  32  captured retire PC.
REQ-015 exc_count  output  8  number of exceptions captured since rst; saturates at 255.
REQ-016 halted  output  1  core stopped and awaiting restart.

Function
REQ-017 FSM states: HOLD, RUN, REPORT, HALT.
REQ-018 HOLD: core_rst=1; a 4-bit counter loads HOLD_CYCLES-1 on entry and decrements each cycle; at 0, go to RUN next cycle.
REQ-019 HOLD lasts exactly HOLD_CYCLES cycles of core_rst=1.
REQ-020 RUN: core_rst=0; exc_in is sampled every cycle.
REQ-021 In RUN with exc_in!=0: capture rep_code<=exc_in, rep_pc<=exc_pc and rep_cause, increment exc_count, and go to REPORT; core_rst=1 from the next cycle on.
REQ-022 rep_cause is computed combinationally at capture time from exc_in, then registered.
REQ-023 A multi-bit exc_in is captured whole; rep_cause takes the lowest set bit.
REQ-024 exc_in is ignored in HOLD, REPORT and HALT; the core is in reset then, and a stray value is neither captured nor counted.
REQ-025 REPORT: core_rst=1, rep_valid=1.
REQ-026 rep_code, rep_pc and rep_cause are stable while rep_valid=1.
REQ-027 Handshake completes on the cycle where rep_valid&rep_ready=1.
REQ-028 On handshake, rep_valid drops next cycle; go to HOLD if AUTO_RESTART=1, else to HALT.
REQ-029 rep_ready while rep_valid=0 has no effect.
REQ-030 HALT: core_rst=1, halted=1; restart_req=1 goes to HOLD next cycle.
REQ-031 restart_req is ignored in all states except HALT.
REQ-032 The captured report registers retain their values after the handshake, until the next capture.
REQ-033 exc_count holds at 255 when already saturated.
REQ-034 Outputs are registered; the only combinational path is none, i.e. no input reaches an output in the same cycle.

Reset
REQ-035 rst low asynchronously forces state=HOLD and the hold counter to HOLD_CYCLES-1.
REQ-036 rst low also forces core_rst=1, rep_valid=0, halted=0, rep_code=0, rep_cause=0, rep_pc=0, exc_count=0.
REQ-037 After rst deasserts, the normal HOLD sequence runs.
REQ-038 rst asserted mid-REPORT abandons the pending report with no handshake.

Structure
REQ-039 A shared package holds the FSM state encoding (2-bit: HOLD=0, RUN=1, REPORT=2, HALT=3), the exception vector width (10) and the cause width (4).
REQ-040 The priority encoder is a sub-module, exc_prio_enc: 10-bit vector in, 4-bit index plus any-set flag out.
REQ-041 Everything else is a single flat module.

Verification
REQ-042 Release rst with HOLD_CYCLES=4 -> core_rst=1 for exactly 4 cycles, then 0; exc_count=0.
REQ-043 In RUN, exc_in=10'b0000100100 with exc_pc=0x34 -> rep_valid=1, rep_code=0x024, rep_cause=2, rep_pc=0x34, exc_count=1; core_rst=1 from the next cycle.
REQ-044 Hold rep_ready=0 for 5 cycles while exc_in toggles -> rep_* unchanged and exc_count unchanged; then rep_ready=1 with AUTO_RESTART=0 -> halted=1, rep_valid=0.
REQ-045 AUTO_RESTART=1, handshake -> 4 HOLD cycles, then RUN with no host action.
REQ-046 Force 256 traps -> exc_count stays at 255.
REQ-047 Assert rst during REPORT -> all outputs reach reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/exception_monitor_pkg.sv
// Shared definitions for the exception monitor: FSM state encoding and the
// widths of the exception vector, the cause index and the counters.
package exception_monitor_pkg;

   localparam int EXC_W   = 10;   // width of the core's final exception vector
   localparam int CAUSE_W = 4;    // width of the lowest-set-bit index
   localparam int PC_W    = 32;   // retire PC width
   localparam int CNT_W   = 8;    // saturating exception counter width
   localparam int HOLD_W  = 4;    // hold-cycle down-counter width

   // Monitor FSM; the encoding is fixed so it can be observed on dbg_state.
   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,   // core held in reset for HOLD_CYCLES cycles
      ST_RUN    = 2'd1,   // core running, exception vector watched
      ST_REPORT = 2'd2,   // trap captured, report offered to the host
      ST_HALT   = 2'd3    // core stopped, waiting for a host restart
   } state_e;

endpackage

// File: rtl/exception_monitor_prio_enc.sv
// Lowest-set-bit priority encoder for the exception vector. Bit 0 has the
// highest priority; idx_o is 0 when no bit is set (any_o tells them apart).
module exc_prio_enc
   import exception_monitor_pkg::*;
(
   input  logic [EXC_W-1:0]   vec_i,
   output logic [CAUSE_W-1:0] idx_o,
   output logic               any_o
);

   // Scan from the top bit down so the lowest set bit is the last to write idx_o.
   always_comb begin
      idx_o = '0;
      any_o = |vec_i;
      for (int i = EXC_W - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = CAUSE_W'(i);
         end
      end
   end

endmodule

// File: rtl/exception_monitor.sv
// Exception monitor: holds a core in reset for a fixed number of cycles,
// lets it run, captures the first trapping retirement (vector, PC, cause),
// offers it to the host with a valid/ready handshake and then either halts
// the core or restarts it automatically.
//
// Handshake: rep_valid rises with a captured report and stays high, with
// rep_code/rep_cause/rep_pc frozen, until the first cycle in which rep_ready
// is also high; that cycle completes the transfer and rep_valid drops on the
// next cycle. rep_ready has no effect while rep_valid is low.
module exception_monitor
   import exception_monitor_pkg::*;
#(
   parameter int HOLD_CYCLES  = 4,     // 1..15 cycles of core_rst per (re)start
   parameter bit AUTO_RESTART = 1'b0   // 1: restart the core after each report
) (
   input  logic               clk,
   input  logic               rst,          // asynchronous, active low
   input  logic [EXC_W-1:0]   exc_in,
   input  logic [PC_W-1:0]    exc_pc,
   input  logic               restart_req,
   input  logic               rep_ready,
   output logic               core_rst,
   output logic               rep_valid,
   output logic [EXC_W-1:0]   rep_code,
   output logic [CAUSE_W-1:0] rep_cause,
   output logic [PC_W-1:0]    rep_pc,
   output logic [CNT_W-1:0]   exc_count,
   output logic               halted,
   output logic [1:0]         dbg_state
);

   // Value loaded into the hold counter on every entry into HOLD.
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_e               state_q, state_d;
   logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic                 core_rst_q, core_rst_d;
   logic                 rep_valid_q, rep_valid_d;
   logic                 halted_q, halted_d;
   logic [EXC_W-1:0]     rep_code_q, rep_code_d;
   logic [CAUSE_W-1:0]   rep_cause_q, rep_cause_d;
   logic [PC_W-1:0]      rep_pc_q, rep_pc_d;
   logic [CNT_W-1:0]     exc_count_q, exc_count_d;

   logic [CAUSE_W-1:0]   enc_idx;
   logic                 enc_any;
   logic                 capture;

   // Cause index of the incoming vector, used only on the capture cycle.
   exc_prio_enc u_prio_enc (
      .vec_i (exc_in),
      .idx_o (enc_idx),
      .any_o (enc_any)
   );

   // Next-state logic: hold countdown, trap detection, handshake, restart.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      capture    = 1'b0;
      case (state_q)
         ST_HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end
         ST_RUN: begin
            // Any nonzero vector means the retiring instruction trapped.
            if (enc_any) begin
               capture = 1'b1;
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (rep_ready) begin
               if (AUTO_RESTART) begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = HOLD_LOAD;
               end else begin
                  state_d = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            if (restart_req) begin
               state_d    = ST_HOLD;
               hold_cnt_d = HOLD_LOAD;
            end
         end
         default: begin
            state_d    = ST_HOLD;
            hold_cnt_d = HOLD_LOAD;
         end
      endcase
   end

   // Output flags are decoded from the next state so they leave a flop.
   always_comb begin
      core_rst_d  = (state_d != ST_RUN);
      rep_valid_d = (state_d == ST_REPORT);
      halted_d    = (state_d == ST_HALT);
   end

   // Report datapath: load on capture, otherwise keep the last report.
   always_comb begin
      rep_code_d  = rep_code_q;
      rep_cause_d = rep_cause_q;
      rep_pc_d    = rep_pc_q;
      exc_count_d = exc_count_q;
      if (capture) begin
         rep_code_d  = exc_in;
         rep_cause_d = enc_idx;
         rep_pc_d    = exc_pc;
         if (exc_count_q != CNT_MAX) begin
            exc_count_d = exc_count_q + 1'b1;
         end
      end
   end

   // Control state register and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_HOLD;
         hold_cnt_q  <= HOLD_LOAD;
         core_rst_q  <= 1'b1;
         rep_valid_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         core_rst_q  <= core_rst_d;
         rep_valid_q <= rep_valid_d;
         halted_q    <= halted_d;
      end
   end

   // Captured report registers and the saturating exception counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_code_q  <= '0;
         rep_cause_q <= '0;
         rep_pc_q    <= '0;
         exc_count_q <= '0;
      end else begin
         rep_code_q  <= rep_code_d;
         rep_cause_q <= rep_cause_d;
         rep_pc_q    <= rep_pc_d;
         exc_count_q <= exc_count_d;
      end
   end

   assign core_rst  = core_rst_q;
   assign rep_valid = rep_valid_q;
   assign rep_code  = rep_code_q;
   assign rep_cause = rep_cause_q;
   assign rep_pc    = rep_pc_q;
   assign exc_count = exc_count_q;
   assign halted    = halted_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_exception_monitor.sv
// Bench for exception_monitor: instance 0 runs with AUTO_RESTART=0, instance 1
// with AUTO_RESTART=1, both with HOLD_CYCLES=4. The driver pushes the expected
// report whenever it presents a trap in RUN; a negedge monitor pops it when
// rep_valid rises and otherwise requires the report registers to hold.
module tb_exception_monitor;

   localparam int W    = 54;   // {code10, cause4, pc32, count8}
   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst         [2];
   logic [9:0]  exc_in      [2];
   logic [31:0] exc_pc      [2];
   logic        restart_req [2];
   logic        rep_ready   [2];
   logic        core_rst    [2];
   logic        rep_valid   [2];
   logic [9:0]  rep_code    [2];
   logic [3:0]  rep_cause   [2];
   logic [31:0] rep_pc      [2];
   logic [7:0]  exc_count   [2];
   logic        halted      [2];
   logic [1:0]  dbg_state   [2];

   logic [W-1:0] exp_q0 [$];
   logic [W-1:0] exp_q1 [$];
   logic [W-1:0] last_rep [2];
   bit           prev_v   [2];
   int           n_caps   [2];
   int           n_checks = 0;
   int           n_errors = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   exception_monitor #(.HOLD_CYCLES(HOLD), .AUTO_RESTART(1'b0)) u_dut0 (
      .clk(clk), .rst(rst[0]), .exc_in(exc_in[0]), .exc_pc(exc_pc[0]),
      .restart_req(restart_req[0]), .rep_ready(rep_ready[0]),
      .core_rst(core_rst[0]), .rep_valid(rep_valid[0]), .rep_code(rep_code[0]),
      .rep_cause(rep_cause[0]), .rep_pc(rep_pc[0]), .exc_count(exc_count[0]),
      .halted(halted[0]), .dbg_state(dbg_state[0])
   );

   exception_monitor #(.HOLD_CYCLES(HOLD), .AUTO_RESTART(1'b1)) u_dut1 (
      .clk(clk), .rst(rst[1]), .exc_in(exc_in[1]), .exc_pc(exc_pc[1]),
      .restart_req(restart_req[1]), .rep_ready(rep_ready[1]),
      .core_rst(core_rst[1]), .rep_valid(rep_valid[1]), .rep_code(rep_code[1]),
      .rep_cause(rep_cause[1]), .rep_pc(rep_pc[1]), .exc_count(exc_count[1]),
      .halted(halted[1]), .dbg_state(dbg_state[1])
   );

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference cause: index of the lowest set bit, by plain search.
   function automatic logic [3:0] lowest_bit(input logic [9:0] v);
      for (int i = 0; i < 10; i++) begin
         if (v[i]) return 4'(i);
      end
      return 4'd0;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int d, input logic [W-1:0] e);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   // Core held in reset for HOLD cycles from now, then running.
   task automatic expect_hold(input int d);
      for (int i = 0; i < HOLD; i++) begin
         chk("hold_core_rst", 64'(core_rst[d]), 64'd1);
         if (i == 0) chk("hold_state", 64'(dbg_state[d]), 64'd0);
         exc_in[d]      = 10'($urandom_range(0, 1023));
         exc_pc[d]      = $urandom;
         restart_req[d] = 1'($urandom_range(0, 1));
         rep_ready[d]   = 1'($urandom_range(0, 1));
         cyc();
      end
      exc_in[d]      = '0;
      restart_req[d] = 1'b0;
      rep_ready[d]   = 1'b0;
      chk("run_core_rst", 64'(core_rst[d]), 64'd0);
      chk("run_state", 64'(dbg_state[d]), 64'd1);
   endtask

   // Idle RUN cycles, then one trapping retirement.
   task automatic run_trap(input int d, input int idle, input logic [9:0] code,
                           input logic [31:0] pc);
      logic [7:0] cnt;
      for (int i = 0; i < idle; i++) begin
         exc_in[d]      = '0;
         exc_pc[d]      = $urandom;
         restart_req[d] = 1'($urandom_range(0, 1));
         rep_ready[d]   = 1'($urandom_range(0, 1));
         cyc();
         chk("idle_core_rst", 64'(core_rst[d]), 64'd0);
         chk("idle_rep_valid", 64'(rep_valid[d]), 64'd0);
      end
      exc_in[d]      = code;
      exc_pc[d]      = pc;
      restart_req[d] = 1'($urandom_range(0, 1));
      rep_ready[d]   = 1'($urandom_range(0, 1));
      n_caps[d]++;
      cnt = (n_caps[d] > 255) ? 8'd255 : 8'(n_caps[d]);
      push_exp(d, {code, lowest_bit(code), pc, cnt});
      cyc();
      chk("trap_core_rst", 64'(core_rst[d]), 64'd1);
      chk("trap_rep_valid", 64'(rep_valid[d]), 64'd1);
   endtask

   // Host stalls n cycles (stray traps, restarts), then accepts.
   task automatic report_wait(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         rep_ready[d]   = 1'b0;
         exc_in[d]      = 10'($urandom_range(0, 1023));
         exc_pc[d]      = $urandom;
         restart_req[d] = 1'($urandom_range(0, 1));
         cyc();
         chk("stall_rep_valid", 64'(rep_valid[d]), 64'd1);
         chk("stall_core_rst", 64'(core_rst[d]), 64'd1);
      end
      rep_ready[d]   = 1'b1;
      exc_in[d]      = 10'($urandom_range(0, 1023));
      restart_req[d] = 1'b0;
      cyc();
      rep_ready[d] = 1'b0;
      chk("accept_rep_valid", 64'(rep_valid[d]), 64'd0);
      chk("accept_core_rst", 64'(core_rst[d]), 64'd1);
      chk("accept_halted", 64'(halted[d]), (d == 0) ? 64'd1 : 64'd0);
   endtask

   // Halted for n cycles with stray inputs, then a host restart.
   task automatic halt_then_restart(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         restart_req[d] = 1'b0;
         exc_in[d]      = 10'($urandom_range(0, 1023));
         rep_ready[d]   = 1'($urandom_range(0, 1));
         cyc();
         chk("halt_halted", 64'(halted[d]), 64'd1);
         chk("halt_core_rst", 64'(core_rst[d]), 64'd1);
         chk("halt_state", 64'(dbg_state[d]), 64'd3);
      end
      restart_req[d] = 1'b1;
      cyc();
      restart_req[d] = 1'b0;
      chk("restart_halted", 64'(halted[d]), 64'd0);
      expect_hold(d);
   endtask

   task automatic release_reset(input int d);
      rst[d] = 1'b1;
      expect_hold(d);
   endtask

   // Reset pulled mid-report: outputs must clear before the next clock edge.
   task automatic async_reset_check(input int d);
      rst[d]    = 1'b0;
      n_caps[d] = 0;
      #1;
      chk("arst_core_rst", 64'(core_rst[d]), 64'd1);
      chk("arst_rep_valid", 64'(rep_valid[d]), 64'd0);
      chk("arst_halted", 64'(halted[d]), 64'd0);
      chk("arst_rep_code", 64'(rep_code[d]), 64'd0);
      chk("arst_rep_cause", 64'(rep_cause[d]), 64'd0);
      chk("arst_rep_pc", 64'(rep_pc[d]), 64'd0);
      chk("arst_exc_count", 64'(exc_count[d]), 64'd0);
      cyc();
      cyc();
      release_reset(d);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst[d]) begin
            last_rep[d] = '0;
            prev_v[d]   = 1'b0;
            chk("rst_core_rst", 64'(core_rst[d]), 64'd1);
            chk("rst_rep_valid", 64'(rep_valid[d]), 64'd0);
            chk("rst_halted", 64'(halted[d]), 64'd0);
         end else if (rep_valid[d] && !prev_v[d]) begin
            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
               chk("unexpected_report", 64'(rep_valid[d]), 64'd0);
            end else begin
               last_rep[d] = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            end
         end
         if (!rep_valid[d] || !prev_v[d] || rst[d]) begin
            chk("rep_code",  64'(rep_code[d]),  64'(last_rep[d][53:44]));
            chk("rep_cause", 64'(rep_cause[d]), 64'(last_rep[d][43:40]));
            chk("rep_pc",    64'(rep_pc[d]),    64'(last_rep[d][39:8]));
            chk("exc_count", 64'(exc_count[d]), 64'(last_rep[d][7:0]));
         end
         prev_v[d] = rst[d] ? bit'(rep_valid[d]) : 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; exc_in[d] = '0; exc_pc[d] = '0;
         restart_req[d] = 1'b0; rep_ready[d] = 1'b0; n_caps[d] = 0;
         last_rep[d] = '0; prev_v[d] = 1'b0;
      end
      cyc();
      cyc();
      chk("por_core_rst", 64'(core_rst[0]), 64'd1);
      chk("por_exc_count", 64'(exc_count[0]), 64'd0);

      // Instance 0: no auto restart.
      release_reset(0);
      chk("start_exc_count", 64'(exc_count[0]), 64'd0);
      run_trap(0, 3, 10'b0000100100, 32'h34);
      chk("dir_rep_code", 64'(rep_code[0]), 64'h024);
      chk("dir_rep_cause", 64'(rep_cause[0]), 64'd2);
      chk("dir_rep_pc", 64'(rep_pc[0]), 64'h34);
      chk("dir_exc_count", 64'(exc_count[0]), 64'd1);
      report_wait(0, 5);
      halt_then_restart(0, 3);
      for (int k = 0; k < 20; k++) begin
         run_trap(0, $urandom_range(0, 5), 10'($urandom_range(1, 1023)), $urandom);
         report_wait(0, $urandom_range(0, 4));
         halt_then_restart(0, $urandom_range(0, 3));
      end
      run_trap(0, 2, 10'h200, 32'hDEAD_BEEF);
      chk("top_bit_cause", 64'(rep_cause[0]), 64'd9);
      cyc();
      async_reset_check(0);

      // Instance 1: auto restart, driven past counter saturation.
      cyc();
      release_reset(1);
      for (int k = 0; k < 258; k++) begin
         run_trap(1, $urandom_range(0, 2), 10'($urandom_range(1, 1023)), $urandom);
         report_wait(1, $urandom_range(0, 1));
         expect_hold(1);
      end
      chk("sat_exc_count", 64'(exc_count[1]), 64'd255);

      cyc();
      cyc();
      chk("queue0_empty", 64'(exp_q0.size()), 64'd0);
      chk("queue1_empty", 64'(exp_q1.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
